// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: picks sequential fetch, branch redirect, stall or halt
// each cycle, drives the IF/ID flush pulse and keeps a saturating fetch counter.
module pc_sequencer #(
  parameter int              PC_W         = 8,
  parameter logic [PC_W-1:0] START_PC     = 8'h00,
  parameter int              FLUSH_CYCLES = 1,
  parameter int              CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [PC_W-1:0]  branch_target_i,
  input  logic             halt_i,
  output logic [PC_W-1:0]  newpc_o,
  output logic             pc_we_o,
  output logic             flush_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] fetch_count_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_e;

  // Counter value loaded on a redirect: the redirect cycle itself is the first flush cycle.
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       flush_cnt_q, flush_cnt_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
  logic [PC_W-1:0]  pc_inc;

  assign pc_inc = pc_i + 1'b1;

  // Handshake with the PC register: newpc_o is consumed on every rising edge where
  // pc_we_o=1; there is no back-pressure, so a write is always accepted.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    newpc_o     = pc_i;
    pc_we_o     = 1'b0;
    flush_o     = 1'b0;
    unique case (state_q)
      IDLE, HALT: begin
        if (start_i) begin
          newpc_o = START_PC;
          pc_we_o = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (branch_taken_i) begin
          newpc_o = branch_target_i;
          pc_we_o = 1'b1;
          flush_o = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_RELOAD;
          end
        end else if (halt_i) begin
          state_d = HALT;
        end else if (!stall_i) begin
          newpc_o = pc_inc;
          pc_we_o = 1'b1;
        end
      end
      FLUSH: begin
        flush_o = 1'b1;
        pc_we_o = 1'b1;
        if (branch_taken_i) begin
          newpc_o     = branch_target_i;
          flush_cnt_d = FLUSH_RELOAD;
        end else begin
          newpc_o = pc_inc;
          if (flush_cnt_q == 2'd1) begin
            state_d     = RUN;
            flush_cnt_d = 2'd0;
          end else begin
            flush_cnt_d = flush_cnt_q - 2'd1;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        flush_cnt_d = 2'd0;
      end
    endcase

    halted_d = (state_d == HALT);

    if (pc_we_o && (fetch_count_q != {CNT_W{1'b1}})) begin
      fetch_count_d = fetch_count_q + 1'b1;
    end else begin
      fetch_count_d = fetch_count_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      flush_cnt_q   <= 2'd0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign halted_o      = halted_q;
  assign fetch_count_o = fetch_count_q;
  assign dbg_state_o   = state_q;

endmodule
